// File: rtl/qpu_ifu_ir_queue_pkg.sv
// Shared widths and state encoding for the IFU instruction-register queue.
// Sizes mirror the QPU defines so the queue and dispatch logic agree on entry layout.
package qpu_ifu_ir_queue_pkg;

  localparam int QPU_INSTR_SIZE     = 32;
  localparam int QPU_PC_SIZE        = 32;
  localparam int QPU_IR_QUEUE_DEPTH = 4;
  localparam int QPU_IR_ENTRY_W     = QPU_INSTR_SIZE + QPU_PC_SIZE + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } ir_state_e;

  // Occupancy class of a queue holding cnt entries out of depth.
  function automatic ir_state_e ir_state_from_cnt(input int unsigned cnt,
                                                  input int unsigned depth);
    if (cnt == 0)      return ST_EMPTY;
    if (cnt == depth)  return ST_FULL;
    return ST_PARTIAL;
  endfunction

endpackage

// File: rtl/qpu_ifu_ir_queue_if.sv
// Fetch-side and decode-side handshake bundle of the IR queue.
// master = fetch/EXU/branch-unit side, slave = the queue itself.
interface qpu_ifu_ir_queue_if
  import qpu_ifu_ir_queue_pkg::*;
#(
  parameter int DEPTH   = QPU_IR_QUEUE_DEPTH,
  parameter int INSTR_W = QPU_INSTR_SIZE,
  parameter int PC_W    = QPU_PC_SIZE
) ();

  logic                       ifu_o_valid;
  logic                       ifu_o_ready;
  logic [INSTR_W-1:0]         ifu_o_ir;
  logic [PC_W-1:0]            ifu_o_pc;
  logic                       ifu_o_prdt_taken;
  logic                       i_valid;
  logic                       i_ready;
  logic [INSTR_W-1:0]         i_instr;
  logic [PC_W-1:0]            i_pc;
  logic                       i_prdt_taken;
  logic                       flush_req;
  logic [$clog2(DEPTH):0]     ir_count;

  modport master (
    output ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_prdt_taken, i_ready, flush_req,
    input  ifu_o_ready, i_valid, i_instr, i_pc, i_prdt_taken, ir_count
  );

  modport slave (
    input  ifu_o_valid, ifu_o_ir, ifu_o_pc, ifu_o_prdt_taken, i_ready, flush_req,
    output ifu_o_ready, i_valid, i_instr, i_pc, i_prdt_taken, ir_count
  );

endinterface

// File: rtl/qpu_gnrl_fifo_ram.sv
// Generic DEPTH x WIDTH register array: one synchronous write port, one
// asynchronous read port. Shared by the IR queue and the dispatch queue.
module qpu_gnrl_fifo_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // NOTE: the array is reset so the head payload is a defined 0 out of reset;
  // this costs a reset net per bit and rules out inferring a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wen) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/qpu_ifu_ir_queue.sv
// Instruction-register queue between fetch and decode: circular FIFO of {ir, pc, prdt}.
// Optional same-cycle empty-queue bypass when QPU_IR_BYPASS_EN is defined.
module qpu_ifu_ir_queue
  import qpu_ifu_ir_queue_pkg::*;
#(
  parameter int DEPTH   = QPU_IR_QUEUE_DEPTH,
  parameter int INSTR_W = QPU_INSTR_SIZE,
  parameter int PC_W    = QPU_PC_SIZE
) (
  input logic               clk,
  input logic               rst_n,
  qpu_ifu_ir_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = INSTR_W + PC_W + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q,  cnt_d;
  ir_state_e     state_q, state_d;

  logic          stored_valid, ready, byp, enq, deq;
  logic [EW-1:0] wdata, rdata, head;

  // Handshakes come from the registered state only, never from i_ready.
  assign stored_valid = (state_q != ST_EMPTY);
  assign ready        = (state_q != ST_FULL);
  assign wdata        = {bus.ifu_o_ir, bus.ifu_o_pc, bus.ifu_o_prdt_taken};

`ifdef QPU_IR_BYPASS_EN
  assign byp = (state_q == ST_EMPTY) & bus.ifu_o_valid & ~bus.flush_req;
`else
  assign byp = 1'b0;
`endif

  // A bypassed word taken by the EXU this cycle is never written.
  assign enq = bus.ifu_o_valid & ready & ~bus.flush_req & ~(byp & bus.i_ready);
  assign deq = stored_valid & bus.i_ready & ~bus.flush_req;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (bus.flush_req) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      wptr_d = wptr_q + AW'(enq);
      rptr_d = rptr_q + AW'(deq);
      unique case ({enq, deq})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    state_d = ir_state_from_cnt(int'(cnt_d), DEPTH);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= ST_EMPTY;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  qpu_gnrl_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (enq),
    .waddr (wptr_q),
    .wdata (wdata),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  assign head = byp ? wdata : rdata;

  assign bus.ifu_o_ready = ready;
  assign bus.i_valid     = stored_valid | byp;
  assign {bus.i_instr, bus.i_pc, bus.i_prdt_taken} = head;
  assign bus.ir_count    = cnt_q;

endmodule

// File: tb/tb_qpu_ifu_ir_queue.sv
// Self-checking bench for qpu_ifu_ir_queue: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_qpu_ifu_ir_queue;
  import qpu_ifu_ir_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int PW    = 32;
`ifdef QPU_IR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qpu_ifu_ir_queue_if #(.DEPTH(DEPTH), .INSTR_W(IW), .PC_W(PW)) bus ();

  qpu_ifu_ir_queue #(.DEPTH(DEPTH), .INSTR_W(IW), .PC_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [IW-1:0] ir;
    logic [PW-1:0] pc;
    logic          prdt;
  } ent_t;

  ent_t mq[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries updated at each active edge.
  always @(posedge clk or negedge rst_n) begin
    bit mv, mbyp, pop, push;
    if (!rst_n || bus.flush_req) begin
      mq.delete();
    end else begin
      mv   = (mq.size() != 0);
      mbyp = BYP && !mv && bus.ifu_o_valid;
      pop  = mv && bus.i_ready;
      push = bus.ifu_o_valid && (mq.size() < DEPTH) && !(mbyp && bus.i_ready);
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back('{bus.ifu_o_ir, bus.ifu_o_pc, bus.ifu_o_prdt_taken});
    end
  end

  // Compare every cycle on the inactive edge.
  always @(negedge clk) begin
    bit   mbyp, mvalid;
    ent_t h;
    mbyp   = BYP && (mq.size() == 0) && bus.ifu_o_valid && !bus.flush_req;
    mvalid = (mq.size() != 0) || mbyp;
    check("cmp_ifu_o_ready", 64'(bus.ifu_o_ready), 64'(mq.size() < DEPTH));
    check("cmp_i_valid",     64'(bus.i_valid),     64'(mvalid));
    check("cmp_ir_count",    64'(bus.ir_count),    64'(mq.size()));
    if (mvalid) begin
      if (mq.size() != 0) h = mq[0];
      else h = '{bus.ifu_o_ir, bus.ifu_o_pc, bus.ifu_o_prdt_taken};
      check("cmp_i_instr",      64'(bus.i_instr),      64'(h.ir));
      check("cmp_i_pc",         64'(bus.i_pc),         64'(h.pc));
      check("cmp_i_prdt_taken", 64'(bus.i_prdt_taken), 64'(h.prdt));
    end
  end

  task automatic drive(input bit v, input logic [IW-1:0] ir, input logic [PW-1:0] pc,
                       input bit p, input bit rdy, input bit fl);
    bus.ifu_o_valid      = v;
    bus.ifu_o_ir         = ir;
    bus.ifu_o_pc         = pc;
    bus.ifu_o_prdt_taken = p;
    bus.i_ready          = rdy;
    bus.flush_req        = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, '0, '0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    check("rst_ready",  64'(bus.ifu_o_ready),  64'd1);
    check("rst_valid",  64'(bus.i_valid),      64'd0);
    check("rst_count",  64'(bus.ir_count),     64'd0);
    check("rst_instr",  64'(bus.i_instr),      64'd0);
    check("rst_pc",     64'(bus.i_pc),         64'd0);
    check("rst_prdt",   64'(bus.i_prdt_taken), 64'd0);

    // Three pushes held back by i_ready=0, then popped in order.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h1000 + k, 32'(k * 4), k[0], 0, 0);
      step();
    end
    drive(0, '0, '0, 0, 0, 0);
    check("hold_count", 64'(bus.ir_count), 64'd3);
    check("hold_pc0",   64'(bus.i_pc),     64'h0);
    step();
    check("hold_pc0_stable", 64'(bus.i_pc), 64'h0);
    drive(0, '0, '0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      check("pop_order_pc", 64'(bus.i_pc), 64'(k * 4));
      step();
    end
    drive(0, '0, '0, 0, 0, 0);
    check("drained_valid", 64'(bus.i_valid), 64'd0);

    // Fill to DEPTH, offer a fifth word, then pop one.
    for (int k = 0; k < DEPTH; k++) begin
      drive(1, 32'h2000 + k, 32'h100 + 32'(k * 4), 0, 0, 0);
      step();
    end
    check("full_ready", 64'(bus.ifu_o_ready), 64'd0);
    check("full_count", 64'(bus.ir_count),    64'd4);
    drive(1, 32'hdead, 32'h200, 1, 0, 0);
    step();
    check("full_reject_count", 64'(bus.ir_count), 64'd4);
    drive(0, '0, '0, 0, 1, 0);
    step();
    drive(0, '0, '0, 0, 0, 0);
    check("unfull_ready", 64'(bus.ifu_o_ready), 64'd1);
    check("unfull_count", 64'(bus.ir_count),    64'd3);
    check("unfull_head",  64'(bus.i_pc),        64'h104);
    drive(0, '0, '0, 0, 1, 0);
    repeat (3) step();

    // Ten back-to-back words with the EXU always ready: steady occupancy, wrap.
    for (int k = 0; k < 10; k++) begin
      drive(1, 32'h3000 + k, 32'h300 + 32'(k * 4), k[0], 1, 0);
      step();
      check("stream_count", 64'(bus.ir_count), BYP ? 64'd0 : 64'd1);
      check("stream_valid", 64'(bus.i_valid),  64'd1);
      check("stream_pc",    64'(bus.i_pc),     64'h300 + 64'(k * 4));
    end
    drive(0, '0, '0, 0, 1, 0);
    step();

    // Flush with three entries, a word on offer and the EXU ready.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h4000 + k, 32'h10 + 32'(k * 4), 0, 0, 0);
      step();
    end
    drive(1, 32'h4999, 32'h999, 1, 1, 1);
    step();
    drive(0, '0, '0, 0, 0, 0);
    check("flush_count", 64'(bus.ir_count), 64'd0);
    check("flush_valid", 64'(bus.i_valid),  64'd0);
    drive(1, 32'h4040, 32'h40, 0, 0, 0);
    step();
    drive(0, '0, '0, 0, 0, 0);
    check("post_flush_head", 64'(bus.i_pc),    64'h40);
    check("post_flush_cnt",  64'(bus.ir_count), 64'd1);
    drive(0, '0, '0, 0, 1, 0);
    step();

    // Asynchronous reset between edges with two entries held.
    for (int k = 0; k < 2; k++) begin
      drive(1, 32'h5000 + k, 32'h500 + 32'(k * 4), 0, 0, 0);
      step();
    end
    drive(0, '0, '0, 0, 0, 0);
    check("pre_arst_count", 64'(bus.ir_count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(bus.i_valid),     64'd0);
    check("arst_ready", 64'(bus.ifu_o_ready), 64'd1);
    check("arst_count", 64'(bus.ir_count),    64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef QPU_IR_BYPASS_EN
    // Zero-latency bypass into an empty queue.
    drive(1, 32'h0000_0001, 32'h50, 0, 1, 0);
    #1;
    check("byp_valid", 64'(bus.i_valid), 64'd1);
    check("byp_instr", 64'(bus.i_instr), 64'h1);
    step();
    drive(0, '0, '0, 0, 0, 0);
    check("byp_count", 64'(bus.ir_count), 64'd0);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
      step();
    end
    drive(0, '0, '0, 0, 0, 0);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/qpu_ifu_ir_queue.md
# qpu_ifu_ir_queue

Instruction-register queue between the fetch unit and `QPU_exu_decode`. It buffers fetched instruction words together with their PC and branch-prediction bit in a small circular FIFO. It presents the oldest entry to the decoder as `i_instr`/`i_pc`/`i_prdt_taken`, and drops all in-flight entries when the EXU resolves a branch misprediction. Valid/ready handshakes on both sides decouple fetch stalls from EXU stalls, such as long QWAIT timepoints.

## Interface
- `DEPTH`, 4 — entry count; power of two, minimum 2.
- `INSTR_W`, `` `QPU_INSTR_SIZE `` (32) — instruction width.
- `PC_W`, `` `QPU_PC_SIZE `` — PC width.
- `clk` input 1 — single clock for the block.
- `rst_n` input 1 — asynchronous, active-low reset.
- `ifu_o_valid` input 1 — fetch presents an instruction.
- `ifu_o_ready` output 1 — queue accepts it; equals `~full`.
- `ifu_o_ir` input `INSTR_W` — fetched instruction.
- `ifu_o_pc` input `PC_W` — PC of the fetched instruction.
- `ifu_o_prdt_taken` input 1 — fetch predicted this branch taken.
- `i_valid` output 1 — head entry valid toward decode/dispatch.
- `i_ready` input 1 — EXU consumes the head entry.
- `i_instr` output `INSTR_W` — head instruction.
- `i_pc` output `PC_W` — head PC.
- `i_prdt_taken` output 1 — head prediction bit.
- `flush_req` input 1 — misprediction flush from the branch/jump unit.
- `ir_count` output `$clog2(DEPTH)+1` — current occupancy.

## Operation
- Storage is a circular buffer with write pointer `wptr`, read pointer `rptr` and occupancy counter `cnt`.
  - Each pointer is `$clog2(DEPTH)` bits and wraps from `DEPTH-1` to 0 by natural overflow.
- Enqueue: `enq = ifu_o_valid & ifu_o_ready & ~flush_req`.
  - Writes `{ir, pc, prdt}` at `wptr`, then increments `wptr`.
- Dequeue: `deq = i_valid & i_ready & ~flush_req`.
  - Increments `rptr`.
- Counter update: `cnt` gets +1 on enq only, −1 on deq only, and is unchanged on both or neither.
- Full: `cnt == DEPTH`, so `ifu_o_ready = 0`.
  - Simultaneous deq does not open the ready in the same cycle; ready is registered-state based.
- Empty: `cnt == 0`, so `i_valid = 0`.
- Flush: `flush_req = 1` clears `cnt`, `wptr` and `rptr` to 0 on the next edge.
  - Enq and deq presented in the same cycle are ignored.
  - The fetch word offered during flush is discarded; fetch re-presents from the corrected PC.
- Payload outputs are driven from the entry at `rptr`.
  - Their value is don't-care when `i_valid = 0`, but must be stable (no X) after reset.
- Internal state machine, derived from `cnt`: EMPTY, PARTIAL, FULL.
  - EMPTY → PARTIAL on enq.
  - PARTIAL → FULL on enq without deq when `cnt == DEPTH-1`.
  - FULL → PARTIAL on deq.
  - PARTIAL → EMPTY on deq without enq when `cnt == 1`.
  - Any state → EMPTY on flush.
- Entries are never reordered or duplicated. Instruction, PC and prediction bit always travel as one atomic entry.

## Timing
- Reset (async assert, sync release): `cnt`, `wptr` and `rptr` are 0.
  - Outputs: `ifu_o_ready = 1`, `i_valid = 0`, `ir_count = 0`.
  - `i_instr`, `i_pc` and `i_prdt_taken` are 0 (storage reset to 0).
- Latency without bypass: a word enqueued at edge N is visible on `i_*` with `i_valid = 1` after edge N.
  - This is 1 cycle.
- Throughput: 1 instruction per cycle sustained when `i_ready` stays high.
- `ifu_o_ready` and `i_valid` depend only on registered state (no combinational path from `i_ready` to `ifu_o_ready`), except in bypass mode.
- Reset asserted mid-stream discards all entries immediately and asynchronously.

## Configuration
- Macro: `QPU_IR_BYPASS_EN`.
- Defined: when the queue is empty and `ifu_o_valid = 1`, `i_valid` is asserted combinationally and `i_*` are driven from `ifu_o_*`.
  - If `i_ready = 1` in that cycle, the word is consumed without being written, and `cnt` stays 0.
  - If `i_ready = 0`, the word is enqueued normally.
  - Flush still suppresses both outputs.
  - Latency is 0 cycles when the queue is empty.
- Undefined: no bypass path. Latency is always ≥1 cycle, and `i_valid` is purely registered.

## Structure
- Shared package/defines (`QPU_defines.v`) holds:
  - `QPU_INSTR_SIZE`, `QPU_PC_SIZE`;
  - new `QPU_IR_QUEUE_DEPTH` (default 4);
  - the entry-width constant `QPU_IR_ENTRY_W = INSTR_SIZE + PC_SIZE + 1`.
- One sub-module, `qpu_gnrl_fifo_ram`: a generic `DEPTH × width` register array with write enable, write index and asynchronous read index.
  - It is reusable by the dispatch queue.
- Pointers, counter, state decode, flush and bypass logic live in the top module.

## Test plan
- Reset, then push 3 words (PC 0x0, 0x4, 0x8) with `i_ready = 0` → `ir_count = 3`, `i_pc = 0x0` stable.
  - Then release `i_ready` → words pop in order 0x0, 0x4, 0x8 over 3 cycles.
- Fill to `DEPTH = 4` → `ifu_o_ready = 0` on the cycle after the 4th push, and a 5th offered word is not accepted.
  - One pop → ready returns the next cycle.
- Continuous push and pop over 10 words with `i_ready = 1` → `ir_count` constant at 1 (0 with bypass).
  - No bubble, and pointers wrap past index 3 correctly.
- Queue holding 3 entries, `flush_req = 1` together with `ifu_o_valid = 1` and `i_ready = 1` → the next cycle shows `ir_count = 0`, `i_valid = 0`.
  - The offered word is lost; the following push of PC 0x40 appears at the head.
- Assert `rst_n = 0` asynchronously between edges while 2 entries are held → `i_valid` falls immediately and `ifu_o_ready = 1`.
- With `QPU_IR_BYPASS_EN`: empty queue, push 0x00000001 (a quantum instruction) with `i_ready = 1` → `i_instr = 0x00000001` in the same cycle, and `ir_count` stays 0.
